// File: rtl/nw_fill_scheduler_pkg.sv
// rtl/nw_fill_scheduler_pkg.sv - shared state encoding, neighbour codes and latency constants
package nw_pkg;

  typedef logic [2:0] nw_state_t;

  localparam nw_state_t ST_IDLE  = 3'd0;
  localparam nw_state_t ST_ISSUE = 3'd1;
  localparam nw_state_t ST_DRAIN = 3'd2;
  localparam nw_state_t ST_CALC  = 3'd3;
  localparam nw_state_t ST_WRITE = 3'd4;
  localparam nw_state_t ST_DONE  = 3'd5;

  localparam logic [1:0] CNT_DIAG = 2'd0;
  localparam logic [1:0] CNT_UP   = 2'd1;
  localparam logic [1:0] CNT_LEFT = 2'd2;

  localparam logic [1:0] ISSUE_LEN = 2'd3;
  localparam logic [1:0] DRAIN_LEN = 2'd2;

endpackage

// File: rtl/nw_fill_scheduler_if.sv
// rtl/nw_fill_scheduler_if.sv - read-issue, capture, compute handshake and write port of the fill scheduler
interface nw_fill_scheduler_if #(
  parameter int N = 128
);
  localparam int BitAddr     = $clog2(N + 1);
  localparam int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1);

  logic                   en_read;
  logic [1:0]             count;
  logic [BitAddr:0]       i;
  logic [BitAddr:0]       j;
  logic                   cap_diag;
  logic                   cap_up;
  logic                   cap_left;
  logic                   calc_req;
  logic                   calc_ack;
  logic                   we;
  logic [addr_lenght:0]   waddr;

  modport master (
    output en_read, count, i, j, cap_diag, cap_up, cap_left, calc_req, we, waddr,
    input  calc_ack
  );

  modport slave (
    input  en_read, count, i, j, cap_diag, cap_up, cap_left, calc_req, we, waddr,
    output calc_ack
  );
endinterface

// File: rtl/nw_cell_counter.sv
// rtl/nw_cell_counter.sv - row-major i/j walker over the N x N interior cells
module nw_cell_counter #(
  parameter int N  = 128,
  parameter int IW = $clog2(N + 1) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic          last
);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE      = IW'(1);

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;

  // The final cell does not advance, so a finished run leaves (N-1, N-1) visible.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
    end else if (adv && !last) begin
      if (j_q != LAST_IDX) begin
        j_d = j_q + ONE;
      end else begin
        j_d = '0;
        i_d = i_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign i    = i_q;
  assign j    = j_q;
endmodule

// File: rtl/nw_fill_scheduler.sv
// rtl/nw_fill_scheduler.sv - Needleman-Wunsch fill sequencer: issue reads, capture, compute, write each cell
module nw_fill_scheduler
  import nw_pkg::*;
#(
  parameter int N = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  nw_fill_scheduler_if.master bus
);
  localparam int BitAddr     = $clog2(N + 1);
  localparam int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1);
  localparam int IW          = BitAddr + 1;
  localparam int AW          = addr_lenght + 1;

  localparam logic [AW-1:0] ROW_STRIDE = AW'(N + 1);
  localparam logic [AW-1:0] AONE       = AW'(1);
  localparam logic [1:0]    ISSUE_LAST = ISSUE_LEN - 2'd1;
  localparam logic [1:0]    DRAIN_LAST = DRAIN_LEN - 2'd1;

  nw_state_t  state_q, state_d;
  logic [1:0] sub_q, sub_d;

  logic          cell_clr;
  logic          cell_adv;
  logic          cell_last;
  logic [IW-1:0] cell_i;
  logic [IW-1:0] cell_j;
  logic [AW-1:0] cell_addr;

  nw_cell_counter #(
    .N  (N),
    .IW (IW)
  ) u_cells (
    .clk  (clk),
    .rst  (rst),
    .clr  (cell_clr),
    .adv  (cell_adv),
    .i    (cell_i),
    .j    (cell_j),
    .last (cell_last)
  );

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    cell_clr = 1'b0;
    cell_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cell_clr = 1'b1;
          sub_d    = 2'd0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sub_q == ISSUE_LAST) begin
          sub_d   = 2'd0;
          state_d = ST_DRAIN;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (sub_q == DRAIN_LAST) begin
          sub_d   = 2'd0;
          state_d = ST_CALC;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      ST_CALC: begin
        if (bus.calc_ack) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cell_adv = 1'b1;
        sub_d    = 2'd0;
        state_d  = cell_last ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sub_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
    end
  end

  // Read data trails the issued count by two cycles, so each capture lands two slots after its issue.
  assign cell_addr = (AW'(cell_j) + AONE) + ROW_STRIDE * (AW'(cell_i) + AONE);

  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    bus.en_read  = (state_q == ST_ISSUE);
    bus.count    = (state_q == ST_ISSUE) ? sub_q : CNT_DIAG;
    bus.cap_diag = (state_q == ST_ISSUE) && (sub_q == ISSUE_LAST);
    bus.cap_up   = (state_q == ST_DRAIN) && (sub_q == 2'd0);
    bus.cap_left = (state_q == ST_DRAIN) && (sub_q == 2'd1);
    bus.calc_req = (state_q == ST_CALC);
    bus.we       = (state_q == ST_WRITE);
    bus.waddr    = (state_q == ST_WRITE) ? cell_addr : '0;
    bus.i        = cell_i;
    bus.j        = cell_j;
  end
endmodule
